// File: rtl/aes_inv_pkg.sv
// Shared definitions for the AES-128 inverse cipher core: round count,
// key-schedule round constants, state/FSM types and GF(2^8) helpers.
package aes_inv_pkg;

  localparam int NUM_ROUNDS = 10;

  // Rcon for key-schedule rounds 1..10; the unused slots stay zero
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // State indexed [column][row]; byte [0][0] is the MSB of a 128-bit block
  typedef logic [0:3][0:3][7:0] state_t;

  typedef logic [1:0] fsm_t;
  localparam fsm_t IDLE = 2'd0;
  localparam fsm_t KEXP = 2'd1;
  localparam fsm_t DEC  = 2'd2;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant, enough for the 09/0b/0d/0e coefficients
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t m;
    for (int c = 0; c < 4; c++) begin
      m[c][0] = gmul(s[c][0], 4'he) ^ gmul(s[c][1], 4'hb) ^ gmul(s[c][2], 4'hd) ^ gmul(s[c][3], 4'h9);
      m[c][1] = gmul(s[c][0], 4'h9) ^ gmul(s[c][1], 4'he) ^ gmul(s[c][2], 4'hb) ^ gmul(s[c][3], 4'hd);
      m[c][2] = gmul(s[c][0], 4'hd) ^ gmul(s[c][1], 4'h9) ^ gmul(s[c][2], 4'he) ^ gmul(s[c][3], 4'hb);
      m[c][3] = gmul(s[c][0], 4'hb) ^ gmul(s[c][1], 4'hd) ^ gmul(s[c][2], 4'h9) ^ gmul(s[c][3], 4'he);
    end
    return m;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, purely combinational; one instance per state byte.
module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 sits in the most significant byte of the table
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y = TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; used by the key schedule.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 sits in the most significant byte of the table
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// AES-128 inverse cipher: iterative key expansion (one round key per clock)
// followed by one decryption round per clock, fixed 10-cycle latency.
// Optional debug taps of the state and InvSubBytes outputs: AES_DBG_STATE_EN.
module aes_inv_cipher_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         kdone,
`ifdef AES_DBG_STATE_EN
  output logic         busy,
  output logic [7:0]   sa00, sa01, sa02, sa03, sa10, sa11, sa12, sa13,
  output logic [7:0]   sa20, sa21, sa22, sa23, sa30, sa31, sa32, sa33,
  output logic [7:0]   sa00_sub, sa01_sub, sa02_sub, sa03_sub,
  output logic [7:0]   sa10_sub, sa11_sub, sa12_sub, sa13_sub,
  output logic [7:0]   sa20_sub, sa21_sub, sa22_sub, sa23_sub,
  output logic [7:0]   sa30_sub, sa31_sub, sa32_sub, sa33_sub
`else
  output logic         busy
`endif
);

  import aes_inv_pkg::*;

  fsm_t         fsm;
  logic [3:0]   round;
  state_t       st;
  state_t       rk [0:NUM_ROUNDS];
  state_t       sub_st;
  state_t       added;
  state_t       round_out;
  state_t       prev_key;
  state_t       next_key;
  logic [0:3][7:0] rot_w;
  logic [0:3][7:0] sub_w;

  // InvShiftRows is pure wiring: row r of column c comes from column c-r
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_inv_sbox u_inv_sbox (.x(st[(c + 4 - r) % 4][r]), .y(sub_st[c][r]));
    end
  end

  assign added     = sub_st ^ rk[round];
  assign round_out = (round == 4'd0) ? added : inv_mix_columns(added);

  // Key schedule works from the previous round key, RotWord of its last word
  assign prev_key = rk[round - 4'd1];
  assign rot_w    = {prev_key[3][1], prev_key[3][2], prev_key[3][3], prev_key[3][0]};

  for (genvar i = 0; i < 4; i++) begin : g_ksbox
    aes_sbox u_sbox (.x(rot_w[i]), .y(sub_w[i]));
  end

  // Next round key: first word mixes SubWord and Rcon, the rest chain forward
  always_comb begin
    next_key    = prev_key;
    next_key[0] = prev_key[0] ^ sub_w ^ {RCON[round], 24'h000000};
    next_key[1] = prev_key[1] ^ next_key[0];
    next_key[2] = prev_key[2] ^ next_key[1];
    next_key[3] = prev_key[3] ^ next_key[2];
  end

  // Round-key storage has no reset; kdone alone says whether it is usable
  always_ff @(posedge clk) begin
    if (fsm == IDLE && kld) begin
      rk[0] <= key;
    end else if (fsm == KEXP) begin
      rk[round] <= next_key;
    end
  end

  // Control FSM; kld wins over ld, ld needs a complete key schedule
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= IDLE;
      round    <= 4'd0;
      st       <= '0;
      text_out <= '0;
      done     <= 1'b0;
      kdone    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (kld) begin
            fsm   <= KEXP;
            round <= 4'd1;
            kdone <= 1'b0;
            busy  <= 1'b1;
          end else if (ld && kdone) begin
            fsm   <= DEC;
            round <= 4'(NUM_ROUNDS - 1);
            st    <= text_in ^ rk[NUM_ROUNDS];
            busy  <= 1'b1;
          end
        end
        KEXP: begin
          if (round == 4'(NUM_ROUNDS)) begin
            fsm   <= IDLE;
            round <= 4'd0;
            kdone <= 1'b1;
            busy  <= 1'b0;
          end else begin
            round <= round + 4'd1;
          end
        end
        DEC: begin
          st <= round_out;
          if (round == 4'd0) begin
            fsm      <= IDLE;
            text_out <= round_out;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            round <= round - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_DBG_STATE_EN
  assign {sa00, sa01, sa02, sa03} = {st[0][0], st[1][0], st[2][0], st[3][0]};
  assign {sa10, sa11, sa12, sa13} = {st[0][1], st[1][1], st[2][1], st[3][1]};
  assign {sa20, sa21, sa22, sa23} = {st[0][2], st[1][2], st[2][2], st[3][2]};
  assign {sa30, sa31, sa32, sa33} = {st[0][3], st[1][3], st[2][3], st[3][3]};
  assign {sa00_sub, sa01_sub, sa02_sub, sa03_sub} = {sub_st[0][0], sub_st[1][0], sub_st[2][0], sub_st[3][0]};
  assign {sa10_sub, sa11_sub, sa12_sub, sa13_sub} = {sub_st[0][1], sub_st[1][1], sub_st[2][1], sub_st[3][1]};
  assign {sa20_sub, sa21_sub, sa22_sub, sa23_sub} = {sub_st[0][2], sub_st[1][2], sub_st[2][2], sub_st[3][2]};
  assign {sa30_sub, sa31_sub, sa32_sub, sa33_sub} = {sub_st[0][3], sub_st[1][3], sub_st[2][3], sub_st[3][3]};
`endif

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed-vector bench for aes_inv_cipher_core: known-answer decryptions,
// ignored strobes, mid-operation reset and back-to-back blocks.
module tb_aes_inv_cipher_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic         ld;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;
  logic         kdone;
  logic         busy;

  int tests    = 0;
  int failures = 0;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  aes_inv_cipher_core dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .key      (key),
    .ld       (ld),
    .text_in  (text_in),
    .text_out (text_out),
    .done     (done),
    .kdone    (kdone),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] ct);
    @(negedge clk);
    ld      = 1'b1;
    text_in = ct;
    @(negedge clk);
    ld      = 1'b0;
  endtask

  task automatic loadKey(input logic [127:0] k, input string tag);
    int lat;
    @(negedge clk);
    kld = 1'b1;
    key = k;
    @(negedge clk);
    kld = 1'b0;
    checkOutput($sformatf("%s busy in kexp", tag), 128'(busy), 128'd1);
    lat = 0;
    while (!kdone && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("%s kdone latency", tag), 128'(lat), 128'd10);
  endtask

  // Issues one block, optionally a stray ld sampled injectAt edges later,
  // and watches a fixed window for done pulses
  task automatic runDec(input logic [127:0] ct, input int injectAt, input logic [127:0] ct2,
                        output int firstLat, output int pulses, output logic [127:0] val);
    applyStimulus(ct);
    firstLat = -1;
    pulses   = 0;
    val      = '0;
    for (int lat = 1; lat <= 25; lat++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (firstLat < 0) begin
          firstLat = lat;
          val      = text_out;
        end
      end
      ld = (lat == injectAt - 1);
      if (lat == injectAt - 1) text_in = ct2;
    end
    ld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int pulses;
    int busySeen;
    logic [127:0] val;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h00000000000000000000000000000000,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt:  128'h00000000000000000000000000000000};

    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    #12;
    checkOutput("reset text_out", text_out, 128'd0);
    checkOutput("reset done", 128'(done), 128'd0);
    checkOutput("reset kdone", 128'(kdone), 128'd0);
    checkOutput("reset busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // ld with no key schedule must be ignored
    applyStimulus(vecs[0].ct);
    busySeen = 0;
    pulses   = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busySeen = 1;
      if (done) pulses++;
    end
    checkOutput("nokey busy", 128'(busySeen), 128'd0);
    checkOutput("nokey done", 128'(pulses), 128'd0);
    checkOutput("nokey kdone", 128'(kdone), 128'd0);

    for (int i = 0; i < 3; i++) begin
      loadKey(vecs[i].key, $sformatf("vec%0d", i));
      runDec(vecs[i].ct, 0, '0, lat, pulses, val);
      checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'd10);
      checkOutput($sformatf("vec%0d pulses", i), 128'(pulses), 128'd1);
      checkOutput($sformatf("vec%0d plaintext", i), val, vecs[i].pt);
      checkOutput($sformatf("vec%0d held", i), text_out, vecs[i].pt);
    end

    // Stray ld mid-decryption must not disturb the running block
    loadKey(vecs[0].key, "stray");
    runDec(vecs[0].ct, 5, vecs[1].ct, lat, pulses, val);
    checkOutput("stray latency", 128'(lat), 128'd10);
    checkOutput("stray pulses", 128'(pulses), 128'd1);
    checkOutput("stray plaintext", val, vecs[0].pt);
    checkOutput("stray held", text_out, vecs[0].pt);

    // Back-to-back: second ld sampled on the edge right after done
    applyStimulus(vecs[1].ct);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b first latency", 128'(lat), 128'd10);
    ld      = 1'b1;
    text_in = vecs[0].ct;
    @(negedge clk);
    ld = 1'b0;
    checkOutput("b2b done single pulse", 128'(done), 128'd0);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b second latency", 128'(lat), 128'd10);
    checkOutput("b2b plaintext", text_out, vecs[0].pt);

    // Reset during decryption aborts it and invalidates the key schedule
    loadKey(vecs[0].key, "rstdec");
    applyStimulus(vecs[0].ct);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstdec text_out", text_out, 128'd0);
    checkOutput("rstdec done", 128'(done), 128'd0);
    checkOutput("rstdec kdone", 128'(kdone), 128'd0);
    checkOutput("rstdec busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(vecs[0].ct);
    busySeen = 0;
    pulses   = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busySeen = 1;
      if (done) pulses++;
    end
    checkOutput("rstdec ld ignored busy", 128'(busySeen), 128'd0);
    checkOutput("rstdec ld ignored done", 128'(pulses), 128'd0);
    loadKey(vecs[0].key, "rstdec reload");
    runDec(vecs[0].ct, 0, '0, lat, pulses, val);
    checkOutput("rstdec latency", 128'(lat), 128'd10);
    checkOutput("rstdec plaintext", val, vecs[0].pt);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_core.md
AES_INV_CIPHER_CORE -- requirements
Module: aes_inv_cipher_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port kld, input, 1 bit: key-load strobe.
REQ-004 SHALL have port key, input, 128 bits: AES-128 cipher key, sampled with kld.
REQ-005 SHALL have port ld, input, 1 bit: ciphertext-load strobe.
REQ-006 SHALL have port text_in, input, 128 bits: ciphertext block, sampled with ld.
REQ-007 SHALL have port text_out, output, 128 bits: recovered plaintext.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when text_out is valid.
REQ-009 SHALL have port kdone, output, 1 bit: level, high while a complete key schedule is held.
REQ-010 SHALL have port busy, output, 1 bit: high during key expansion or decryption.

Function
REQ-011 SHALL implement an FSM with states IDLE, KEXP and DEC.
REQ-012 SHALL transition IDLE->KEXP on kld: store key as rk[0], clear kdone, then derive rk[1]..rk[10] on 10 consecutive edges (FIPS-197 expansion, Rcon 01..36); return to IDLE and set kdone after rk[10] is stored.
REQ-013 SHALL transition IDLE->DEC on ld when kdone=1: state <= text_in ^ rk[10], round counter <= 9.
REQ-014 SHALL, in DEC, perform one round per edge: rounds 9..1 apply InvShiftRows, InvSubBytes, AddRoundKey(rk[r]) and InvMixColumns; the final round applies InvShiftRows, InvSubBytes and AddRoundKey(rk[0]) only.
REQ-015 SHALL make text_out valid and pulse done exactly 10 cycles after the ld edge; latency is fixed at 10.
REQ-016 SHALL hold text_out stable until the next done.
REQ-017 SHALL ignore ld when kdone=0 or when busy=1; no state change and no done.
REQ-018 SHALL ignore kld when busy=1.
REQ-019 SHALL give kld priority when ld and kld are both asserted in IDLE; ld is dropped.
REQ-020 SHALL compute all GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; InvMixColumns coefficients are 0e, 0b, 0d, 09.
REQ-021 SHALL keep the round counter 4 bits wide; it never wraps below 0.

Reset
REQ-022 SHALL, on rst low, asynchronously force the FSM to IDLE, text_out=0, done=0, kdone=0, busy=0, and the round counter to 0.
REQ-023 SHALL treat reset asserted mid-KEXP or mid-DEC as aborting the operation: no done pulse, and a new kld is required before any ld.
REQ-024 SHALL NOT reset the round-key storage (rk[0..10]); kdone alone gates its use.

Configuration
REQ-025 SHALL, with macro AES_DBG_STATE_EN defined, add 16 output ports sa00..sa33 (8 bits each, state byte row/column) carrying the current state register and 16 ports sa00_sub..sa33_sub carrying InvSubBytes outputs.
REQ-026 SHALL, without AES_DBG_STATE_EN, omit these ports entirely; functional behaviour is identical.

Structure
REQ-027 SHALL place the following in shared package aes_inv_pkg: NUM_ROUNDS=10, the Rcon table, typedef state_t (4x4 bytes), typedef fsm_t, and xtime/InvMixColumns functions.
REQ-028 SHALL use sub-module aes_inv_sbox (256-entry inverse S-box, combinational), instantiated 16 times.
REQ-029 SHALL use the existing aes_sbox (4 instances) for key expansion.

Verification
REQ-030 Bench SHALL cover FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, done 10 cycles after ld.
REQ-031 Bench SHALL cover FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-032 Bench SHALL cover ld before any kld -> no done and busy stays 0 for 20 cycles.
REQ-033 Bench SHALL cover a second ld at cycle 5 of DEC -> ignored; first result unchanged; exactly one done.
REQ-034 Bench SHALL cover rst low at DEC cycle 6 -> outputs 0, kdone 0, no done; then kld followed by ld decrypts C.1 correctly.
REQ-035 Bench SHALL cover back-to-back ld on the cycle after done with the same key -> second block correct, with no new kld.
